// File: rtl/md_pkg.sv
// Shared encodings and helpers for the multiply/divide unit.
package md_pkg;

  localparam int          MD_ITERS   = 32;
  localparam logic [31:0] MD_DIV0_LO = 32'hFFFF_FFFF;

  // Issue opcodes presented on md_unit.op; 3'b110 and 3'b111 are no-ops.
  typedef enum logic [2:0] {
    MD_MULT  = 3'b000,
    MD_MULTU = 3'b001,
    MD_DIV   = 3'b010,
    MD_DIVU  = 3'b011,
    MD_MTHI  = 3'b100,
    MD_MTLO  = 3'b101
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIN  = 2'd2
  } md_state_e;

  // Two's-complement negate when n is set; used both for operand
  // magnitudes at issue and for sign correction of results.
  function automatic logic [31:0] md_cond_neg(input logic [31:0] v, input logic n);
    return n ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/md_div_step.sv
// One restoring-division step: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep the difference when
// it does not borrow.
module md_div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem_i,
  input  logic         bit_i,
  input  logic [W-1:0] divisor_i,
  output logic [W-1:0] rem_o,
  output logic         q_o
);

  logic [W:0] shifted;
  logic [W:0] diff;

  // Trial subtract on W+1 bits; the top bit of the difference is the borrow.
  always_comb begin
    shifted = {rem_i, bit_i};
    diff    = shifted - {1'b0, divisor_i};
    q_o     = ~diff[W];
    rem_o   = q_o ? diff[W-1:0] : shifted[W-1:0];
  end

endmodule

// File: rtl/md_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
//
// Issue handshake: start is a one-cycle strobe from EX, valid only in the
// cycle the instruction advances. A mul/div issue is accepted only from
// IDLE without cancel; isbusy is the "not ready" indication, high from the
// issue cycle through FIN, and the stall logic must not present start
// while isbusy is high (such a start is dropped). MTHI/MTLO complete at the
// issue edge and never raise isbusy. cancel overrides everything.
module md_unit
  import md_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ITERS  = MD_ITERS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic              cancel,
  output logic              isbusy,
  output logic              done,
  output logic [DATA_W-1:0] HI,
  output logic [DATA_W-1:0] LO
);

  localparam int CW = $clog2(ITERS);
  localparam int AW = 2 * DATA_W;

  md_state_e         state_q;
  logic [CW-1:0]     count_q;
  logic [AW-1:0]     acc_q;      // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
  logic [DATA_W-1:0] opnd_q;     // multiplicand or divisor magnitude
  logic              is_div_q;
  logic              neg_res_q;  // product / quotient must be negated
  logic              neg_rem_q;  // remainder must be negated
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;

  logic              rs_neg;
  logic              rt_neg;
  logic [DATA_W-1:0] rs_mag;
  logic [DATA_W-1:0] rt_mag;
  logic [DATA_W:0]   mul_sum;
  logic [AW-1:0]     mul_next;
  logic [DATA_W-1:0] div_rem;
  logic              div_q;
  logic [AW-1:0]     div_next;
  logic [AW-1:0]     prod;
  logic              div0;
  logic [DATA_W-1:0] fin_hi;
  logic [DATA_W-1:0] fin_lo;

  md_div_step #(.W(DATA_W)) u_div_step (
    .rem_i     (acc_q[AW-1:DATA_W]),
    .bit_i     (acc_q[DATA_W-1]),
    .divisor_i (opnd_q),
    .rem_o     (div_rem),
    .q_o       (div_q)
  );

  // Operand magnitudes and the single multiply / divide step per cycle.
  always_comb begin
    rs_neg   = ~op[0] & rs_data[DATA_W-1];
    rt_neg   = ~op[0] & rt_data[DATA_W-1];
    rs_mag   = md_cond_neg(rs_data, rs_neg);
    rt_mag   = md_cond_neg(rt_data, rt_neg);
    mul_sum  = {1'b0, acc_q[AW-1:DATA_W]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
    mul_next = {mul_sum, acc_q[DATA_W-1:1]};
    div_next = {div_rem, acc_q[DATA_W-2:0], div_q};
  end

  // Sign-corrected results; a zero divisor keeps the all-ones quotient and
  // the restored remainder gives back the original rs value.
  always_comb begin
    prod   = neg_res_q ? (~acc_q + AW'(1)) : acc_q;
    div0   = (opnd_q == '0);
    fin_hi = is_div_q ? md_cond_neg(acc_q[AW-1:DATA_W], neg_rem_q) : prod[AW-1:DATA_W];
    fin_lo = is_div_q ? md_cond_neg(acc_q[DATA_W-1:0], neg_res_q & ~div0) : prod[DATA_W-1:0];
  end

  // Busy covers the issue cycle combinationally so HI/LO readers stall at once.
  always_comb begin
    isbusy = (state_q != MD_IDLE) |
             (start & ~cancel & ~op[2] & (state_q == MD_IDLE));
    done   = (state_q == MD_FIN) & ~cancel;
  end

  assign HI = hi_q;
  assign LO = lo_q;

  // Control FSM plus datapath registers; cancel aborts from any state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= MD_IDLE;
      count_q   <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else if (cancel) begin
      state_q <= MD_IDLE;
      count_q <= '0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (start) begin
            case (op)
              MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                is_div_q  <= op[1];
                neg_res_q <= rs_neg ^ rt_neg;
                neg_rem_q <= rs_neg;
                count_q   <= '0;
                state_q   <= MD_CALC;
                if (op[1]) begin
                  acc_q  <= {{DATA_W{1'b0}}, rs_mag};
                  opnd_q <= rt_mag;
                end else begin
                  acc_q  <= {{DATA_W{1'b0}}, rt_mag};
                  opnd_q <= rs_mag;
                end
              end
              MD_MTHI: hi_q <= rs_data;
              MD_MTLO: lo_q <= rs_data;
              default: ;
            endcase
          end
        end
        MD_CALC: begin
          acc_q   <= is_div_q ? div_next : mul_next;
          count_q <= count_q + 1'b1;
          if (count_q == CW'(ITERS - 1)) begin
            state_q <= MD_FIN;
          end
        end
        MD_FIN: begin
          hi_q    <= fin_hi;
          lo_q    <= fin_lo;
          state_q <= MD_IDLE;
        end
        default: state_q <= MD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: a countdown-and-arithmetic reference model, a per-cycle
// compare process, directed cases with literal expectations, random traffic.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic        cancel = 1'b0;
  logic        isbusy;
  logic        done;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_checks = 0;
  int n_err    = 0;
  int viol_cnt = 0;
  logic chk_en = 1'b0;

  // Reference model state.
  int          m_left = 0;   // cycles still busy after the issue edge
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [63:0] exp_q[$];     // pending {HI, LO} results

  md_unit dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .cancel  (cancel),
    .isbusy  (isbusy),
    .done    (done),
    .HI      (HI),
    .LO      (LO)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result of a mul/div as {HI, LO}.
  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint q;
    longint r;
    logic [63:0] ua = {32'd0, a};
    logic [63:0] ub = {32'd0, b};
    logic [63:0] uq;
    logic [63:0] ur;
    case (o)
      3'd0: return 64'(sa * sb);
      3'd1: return ua * ub;
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (o == 3'd2) begin
          q = sa / sb;
          r = sa % sb;
          return {r[31:0], q[31:0]};
        end
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
    endcase
  endfunction

  // Reference model: an accepted mul/div is busy 33 cycles past its issue
  // edge and commits at the last of them; cancel or reset discards it.
  always @(posedge clk) begin
    if (rst) begin
      m_left <= 0;
      m_hi   <= '0;
      m_lo   <= '0;
      exp_q.delete();
    end else if (cancel) begin
      m_left <= 0;
      exp_q.delete();
    end else if (m_left > 0) begin
      if (m_left == 1) begin
        m_hi <= exp_q[0][63:32];
        m_lo <= exp_q[0][31:0];
        void'(exp_q.pop_front());
      end
      m_left <= m_left - 1;
    end else if (start) begin
      if (op inside {3'd0, 3'd1, 3'd2, 3'd3}) begin
        exp_q.push_back(ref_result(op, rs_data, rt_data));
        m_left <= 33;
      end else if (op == 3'd4) begin
        m_hi <= rs_data;
      end else if (op == 3'd5) begin
        m_lo <= rs_data;
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("isbusy", isbusy, (m_left > 0) || (start && !cancel && (op inside {3'd0, 3'd1, 3'd2, 3'd3})));
      chk("done", done, (m_left == 1) && !cancel);
      chk("HI", HI, m_hi);
      chk("LO", LO, m_lo);
    end
  end

  // Protocol monitor: start must never arrive while an operation is in flight.
  always @(negedge clk) begin
    if (chk_en && !rst && start && m_left > 0) begin
      viol_cnt++;
      $display("note: start presented while busy at %0t (dropped by the unit)", $time);
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Issue one op and follow it until isbusy falls; returns busy/done counts.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int nb, output int nd);
    step();
    op = o; rs_data = a; rt_data = b; start = 1'b1;
    nb = 0; nd = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!isbusy) break;
      nb++;
      if (done) nd++;
      step();
      start = 1'b0;
    end
    if (start) begin
      step();
      start = 1'b0;
    end
    if (nb >= 60) chk("run_op_timeout", 64'(nb), 64'd34);
  endtask

  task automatic wait_idle;
    int t = 0;
    while (isbusy && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("wait_idle_bound", 64'(t < 100), 64'd1);
  endtask

  function automatic logic [31:0] rand_word;
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int nb;
    int nd;
    int cancel_at;

    // Reset and idle state.
    repeat (2) step();
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_HI", HI, 32'h0);
    chk("reset_LO", LO, 32'h0);
    chk("reset_isbusy", isbusy, 1'b0);
    chk("reset_done", done, 1'b0);

    // Reset in the middle of CALC discards the operation.
    step();
    op = 3'd1; rs_data = 32'hFFFF_FFFF; rt_data = 32'd3; start = 1'b1;
    step();
    start = 1'b0;
    repeat (10) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("midreset_isbusy", isbusy, 1'b0);
    chk("midreset_HI", HI, 32'h0);
    chk("midreset_LO", LO, 32'h0);

    // MULTU max * max: latency and single done pulse.
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, nb, nd);
    chk("multu_busy_cycles", 64'(nb), 64'd34);
    chk("multu_done_pulses", 64'(nd), 64'd1);
    chk("multu_HI", HI, 32'hFFFF_FFFE);
    chk("multu_LO", LO, 32'h0000_0001);

    run_op(3'd0, 32'hFFFF_FFFD, 32'd7, nb, nd);
    chk("mult_HI", HI, 32'hFFFF_FFFF);
    chk("mult_LO", LO, 32'hFFFF_FFEB);

    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, nb, nd);
    chk("div_neg_LO", LO, 32'hFFFF_FFFD);
    chk("div_neg_HI", HI, 32'hFFFF_FFFF);

    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, nb, nd);
    chk("div_ovf_LO", LO, 32'h8000_0000);
    chk("div_ovf_HI", HI, 32'h0);

    run_op(3'd3, 32'd5, 32'd0, nb, nd);
    chk("divu0_busy_cycles", 64'(nb), 64'd34);
    chk("divu0_HI", HI, 32'd5);
    chk("divu0_LO", LO, 32'hFFFF_FFFF);

    run_op(3'd2, 32'hFFFF_FFF0, 32'd0, nb, nd);
    chk("div0_neg_HI", HI, 32'hFFFF_FFF0);
    chk("div0_neg_LO", LO, 32'hFFFF_FFFF);

    // Cancel during CALC leaves HI/LO untouched.
    run_op(3'd4, 32'h11, 32'd0, nb, nd);
    chk("mthi_busy", 64'(nb), 64'd0);
    run_op(3'd5, 32'h22, 32'd0, nb, nd);
    step();
    op = 3'd3; rs_data = 32'd100; rt_data = 32'd7; start = 1'b1;
    step();
    start = 1'b0;
    repeat (10) step();
    cancel = 1'b1;
    @(negedge clk);
    chk("cancel_done", done, 1'b0);
    step();
    cancel = 1'b0;
    @(negedge clk);
    chk("cancel_isbusy", isbusy, 1'b0);
    chk("cancel_HI", HI, 32'h11);
    chk("cancel_LO", LO, 32'h22);
    run_op(3'd5, 32'h55, 32'd0, nb, nd);
    chk("mtlo_busy", 64'(nb), 64'd0);
    chk("mtlo_LO", LO, 32'h55);

    // Start together with cancel: nothing begins.
    step();
    op = 3'd2; rs_data = 32'd9; rt_data = 32'd3; start = 1'b1; cancel = 1'b1;
    @(negedge clk);
    chk("startcancel_isbusy_issue", isbusy, 1'b0);
    step();
    start = 1'b0; cancel = 1'b0;
    @(negedge clk);
    chk("startcancel_isbusy_after", isbusy, 1'b0);

    // Reserved opcode: no effect.
    run_op(3'd6, 32'hABCD, 32'd1, nb, nd);
    chk("reserved_busy", 64'(nb), 64'd0);
    chk("reserved_LO", LO, 32'h55);

    // MTHI while busy is dropped.
    step();
    op = 3'd1; rs_data = 32'd3; rt_data = 32'd5; start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    op = 3'd4; rs_data = 32'hDEAD; start = 1'b1;
    step();
    start = 1'b0;
    wait_idle();
    chk("busy_mthi_HI", HI, 32'h0);
    chk("busy_mthi_LO", LO, 32'd15);

    // Random traffic with occasional cancels.
    for (int n = 0; n < 40; n++) begin
      step();
      cancel_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 35)) : 99;
      op = 3'($urandom_range(0, 7));
      rs_data = rand_word();
      rt_data = rand_word();
      start = 1'b1;
      for (int c = 0; c < 36; c++) begin
        cancel = (c == cancel_at);
        step();
        start = 1'b0;
      end
      cancel = 1'b0;
    end

    chk("start_while_busy_seen", 64'(viol_cnt), 64'd1);
    step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
Multi-cycle multiply/divide unit with an architectural HI/LO register pair. It sits beside the EX stage. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO issues and produces the isbusy signal that the pipeline stall logic consumes, together with its register-read check, to hold HI/LO readers in ID. Operation is iterative, one bit per cycle, and can be aborted by an exception flush.

Parameters:
DATA_W, 32, operand width. Only 32 is supported; HI/LO are each DATA_W bits.
ITERS, 32, iteration count per mul/div. Must equal DATA_W.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  reset, synchronous, active-high.
start  in  1  issue strobe from EX. The issuer asserts it only in the cycle the instruction advances (EX_MEM1Wr=1).
op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO. 110/111 are reserved and treated as no-op.
rs_data  in  32  forwarded rs operand; dividend or multiplicand, or the MTHI/MTLO source.
rt_data  in  32  forwarded rt operand; divisor or multiplier.
cancel  in  1  exception flush (MEM1_ee). Aborts any in-flight operation.
isbusy  out  1  high while a mul/div is in flight, including its issue cycle.
done  out  1  one-cycle pulse in the commit cycle.
HI  out  32  HI register, driven directly from the flop.
LO  out  32  LO register, driven directly from the flop.

Behaviour:
- Reset: state=IDLE, HI=0, LO=0, count=0, done=0, isbusy=0. Reset mid-operation discards it with no HI/LO write.
- States: IDLE, CALC, FIN. The encoding is a 2-bit one-hot-free binary encoding defined in the package.
- IDLE, start=1, cancel=0, op in {MULT,MULTU,DIV,DIVU}:
  - Latch operands. For signed ops, latch magnitudes plus the sign flags (quotient/product negative = sign(rs) XOR sign(rt); remainder negative = sign(rs)).
  - Set count=0 and go to CALC.
- IDLE, start=1, cancel=0, op=MTHI/MTLO: write HI/LO from rs_data at that edge. isbusy and done are not asserted.
- isbusy = (state != IDLE) | (start & ~cancel & op is mul/div & state==IDLE). It is combinational, so an MFHI in ID during the issue cycle stalls.
- CALC, one step per cycle, count increments each cycle:
  - Multiply: shift-add on a 64-bit accumulator.
  - Divide: restoring; 33-bit trial subtract of the divisor from the partial remainder; quotient bit = no-borrow.
  - When count==ITERS-1, go to FIN. CALC lasts exactly 32 cycles.
- FIN:
  - Apply sign correction by two's-complement negation.
  - Write HI/LO at the exit edge: mul gives HI=product[63:32], LO=product[31:0]; div gives LO=quotient, HI=remainder.
  - done=1 for this cycle only, then return to IDLE.
- Latency: isbusy is high for 34 consecutive cycles (issue cycle + 32 CALC + FIN). New HI/LO values are visible in the cycle after FIN.
- Divide by zero: full latency. Result HI=rs_data, LO=32'hFFFF_FFFF for both DIV and DIVU; no sign correction.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. This falls out of 32-bit magnitude arithmetic.
- cancel has priority in every state, including FIN and the issue cycle:
  - Next state is IDLE, with no HI/LO write and no done.
  - isbusy drops in the cycle after cancel, or immediately in the issue cycle.
- start while state != IDLE is ignored, including MTHI/MTLO. The stall logic guarantees it never happens; the bench asserts this.
- start=1 with a reserved op: no effect.

Decomposition:
- Package md_pkg:
  - op encodings MD_MULT..MD_MTLO;
  - state encodings MD_IDLE/MD_CALC/MD_FIN;
  - MD_ITERS=32;
  - the divide-by-zero LO constant 32'hFFFF_FFFF.
- One sub-module, md_div_step: purely combinational single restoring-division step.
  - Inputs: 32-bit partial remainder, next dividend bit, divisor.
  - Outputs: next remainder, quotient bit.
- The multiply step and the FSM stay in md_unit.

Test Plan:
- Reset, then idle → HI=0, LO=0, isbusy=0, done=0. Reset asserted at CALC count=10 → IDLE next cycle, HI/LO stay 0.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → isbusy high exactly 34 cycles; done a single pulse; then HI=0xFFFFFFFE, LO=0x00000001.
- MULT 0xFFFFFFFD (−3) × 7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. DIV −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0. DIVU 5/0 → HI=5, LO=0xFFFFFFFF after 34 cycles.
- With HI=0x11, LO=0x22, issue DIVU and assert cancel at CALC count=10 → isbusy=0 next cycle, no done, HI/LO stay 0x11/0x22. A following MTLO 0x55 → LO=0x55 at the next edge, isbusy stays 0.
- Start in the same cycle as cancel → no operation begins, isbusy=0. MTHI issued while busy → ignored, and the bench assertion fires.
